// File: rtl/hour_counter_pkg.sv
// Shared time-of-day constants and types used by the second, minute and hour
// counters.
package hour_counter_pkg;

  localparam int unsigned HOURS_PER_DAY           = 24;
  localparam int unsigned MAX_HOUR                = HOURS_PER_DAY - 1;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [4:0] hour_t;

endpackage

// File: rtl/hour_counter_key_debounce.sv
// Key conditioning for a raw active-low push button: 2-flop synchronizer,
// stability timer and a single-cycle press pulse on the debounced 1->0 edge.
module key_debounce
  import hour_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic             key_level;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key into the clk domain; released level is 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Down-counter restarts whenever the sample agrees with the accepted level;
  // the level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_level <= 1'b1;
      cnt       <= RELOAD;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync == key_level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        key_level <= key_sync;
        cnt       <= RELOAD;
        press     <= ~key_sync;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hour_counter.sv
// Hour-of-day counter (0-23) driven by the minute carry, with debounced
// add/reduce keys, optional 12-hour display and a day rollover pulse.
module hour_counter
  import hour_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned RESET_HOUR      = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       min_carry,
  input  logic       hour_add_n,
  input  logic       hour_reduce_n,
  input  logic       mode_12h,
  output bcd_digit_t hour_tens,
  output bcd_digit_t hour_ones,
  output logic       pm,
  output logic       day_carry
);

  localparam hour_t LAST_HOUR = hour_t'(MAX_HOUR);

  hour_t hours, hours_nxt;
  hour_t disp;
  logic  min_carry_prev;
  logic  add_press, red_press;
  logic  add_pend, red_pend, add_pend_nxt, red_pend_nxt;
  logic  day_carry_nxt;
  logic  carry_evt, add_req, red_req, do_inc, do_dec;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add_deb (
    .clk   (clk),
    .reset (reset),
    .key_n (hour_add_n),
    .press (add_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_red_deb (
    .clk   (clk),
    .reset (reset),
    .key_n (hour_reduce_n),
    .press (red_press)
  );

  // Arbitrate carry > add > reduce; a losing key press waits in its pending slot.
  always_comb begin
    carry_evt     = min_carry & ~min_carry_prev;
    add_req       = add_press | add_pend;
    red_req       = red_press | red_pend;
    hours_nxt     = hours;
    add_pend_nxt  = add_req;
    red_pend_nxt  = red_req;
    day_carry_nxt = 1'b0;
    do_inc        = 1'b0;
    do_dec        = 1'b0;
    if (carry_evt) begin
      do_inc = 1'b1;
    end else if (add_req) begin
      do_inc       = 1'b1;
      add_pend_nxt = 1'b0;
    end else if (red_req) begin
      do_dec       = 1'b1;
      red_pend_nxt = 1'b0;
    end
    if (do_inc) begin
      if (hours == LAST_HOUR) begin
        hours_nxt     = '0;
        day_carry_nxt = 1'b1;
      end else begin
        hours_nxt = hours + 1'b1;
      end
    end else if (do_dec) begin
      hours_nxt = (hours == '0) ? LAST_HOUR : hours - 1'b1;
    end
  end

  // Hour state, pending slots and rollover pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hours          <= hour_t'(RESET_HOUR);
      min_carry_prev <= 1'b0;
      add_pend       <= 1'b0;
      red_pend       <= 1'b0;
      day_carry      <= 1'b0;
    end else begin
      hours          <= hours_nxt;
      min_carry_prev <= min_carry;
      add_pend       <= add_pend_nxt;
      red_pend       <= red_pend_nxt;
      day_carry      <= day_carry_nxt;
    end
  end

  // Display value (12-hour folding) and BCD split; purely a view of hours.
  always_comb begin
    disp = hours;
    if (mode_12h) begin
      if (hours == '0) begin
        disp = hour_t'(12);
      end else if (hours > hour_t'(12)) begin
        disp = hours - hour_t'(12);
      end
    end
    if (disp >= hour_t'(20)) begin
      hour_tens = bcd_digit_t'(2);
      hour_ones = bcd_digit_t'(disp - hour_t'(20));
    end else if (disp >= hour_t'(10)) begin
      hour_tens = bcd_digit_t'(1);
      hour_ones = bcd_digit_t'(disp - hour_t'(10));
    end else begin
      hour_tens = bcd_digit_t'(0);
      hour_ones = bcd_digit_t'(disp);
    end
    pm = (hours >= hour_t'(12));
  end

endmodule

// File: doc/hour_counter.md
Name: hour_counter

Overview:
- Downstream stage of the minute counter. Consumes its `min_carry` output and keeps the hour of day (0-23).
- Adds debounced manual set keys, an optional 12-hour display mode, and a day-rollover pulse.
- Outputs are BCD digits that drive the hour pair of seven-segment decoders.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clock cycles a key level must stay stable before it is accepted (20 ms at 50 MHz).
- RESET_HOUR, 23, internal hour value loaded on reset (demo value that exposes rollover quickly).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- min_carry  in  1  minute carry from the minute counter; its rising edge advances the hour.
- hour_add_n  in  1  raw KEY, active-low, asynchronous to clk.
- hour_reduce_n  in  1  raw KEY, active-low, asynchronous to clk.
- mode_12h  in  1  SW level; 1 selects 12-hour display, 0 selects 24-hour display.
- hour_tens  out  4  BCD tens digit of the displayed hour.
- hour_ones  out  4  BCD ones digit of the displayed hour.
- pm  out  1  1 when the internal hour is 12-23 (valid in both modes).
- day_carry  out  1  one-cycle pulse on the 23→0 rollover.

Behaviour:
- Reset (reset=0, asynchronous):
  - internal hours = RESET_HOUR; day_carry = 0; pending = 0.
  - min_carry_prev = 0; debouncers cleared to the released state (1).
  - Outputs take the RESET_HOUR encoding at once: 2/3, pm = 1 in 24-hour mode.
- Key path:
  - Each KEY passes a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - A press is the debounced 1→0 transition and produces one single-cycle pulse.
  - Holding a key produces no further pulses (no auto-repeat).
- Carry event: min_carry==1 while min_carry_prev==0, sampled each cycle.
- Priority per cycle: carry event > add pulse > reduce pulse.
  - A key pulse that loses arbitration is latched as pending (one slot per key).
  - A pending pulse is applied on the next cycle with no carry event, then cleared.
  - A new pulse for a key that already has one pending is merged, not counted twice.
- Increment (carry event or add):
  - hours==23 → hours=0 and day_carry=1 for exactly one cycle.
  - Otherwise hours+1 and day_carry=0.
- Reduce:
  - hours==0 → 23; otherwise hours-1.
  - Never asserts day_carry.
- day_carry is 0 in every cycle without an increment-wrap.
- Latency: hours updates on the first clk edge after the carry edge is sampled, i.e. 1 cycle after min_carry rises.
  - Display outputs are combinational from hours, so they follow in the same cycle.
- Display mapping, 24-hour mode: tens = hours/10, ones = hours%10.
- Display mapping, 12-hour mode:
  - hours 0 → 12.
  - hours 1-12 → unchanged.
  - hours 13-23 → hours-12.
  - The result is then BCD-split.
- pm = (hours >= 12) regardless of mode.
- mode_12h only affects display and may change at any time, with no effect on hours.
- Reset during a debounce count or with a pending event discards that count or event.

Decomposition:
- Shared clock package holds:
  - HOURS_PER_DAY = 24, MAX_HOUR = 23.
  - DEBOUNCE_CYCLES_DEFAULT.
  - A BCD digit typedef (4 bits) reused by the second, minute and hour counters.
- Sub-module: key_debounce. It holds the synchronizer, the counter and the press pulse, and is instantiated twice. Ports:
  - clk, reset.
  - key_n.
  - press (output).
- The minute counter is expected to adopt key_debounce as well.

Test Plan:
- Reset with RESET_HOUR=23, then release → hour_tens=2, hour_ones=3, pm=1, day_carry=0.
- From 23, pulse min_carry high for 3 cycles → exactly one increment; hours=0, outputs 0/0, day_carry high for exactly one cycle, pm=0.
- Bench DEBOUNCE_CYCLES=4:
  - hour_add_n bounces 0/1 every 2 cycles for 20 cycles, then is held low for 10 cycles → one increment (0→1).
  - Releasing with bounce → no change.
- From 0, one debounced hour_reduce press → 23, day_carry stays 0; a further press → 22.
- Add pulse lands in the same cycle as a min_carry rising edge from hours=5 → hours=6 that cycle, hours=7 the following cycle (pending applied).
- mode_12h=1:
  - hours 0 → 1/2 with pm=0.
  - hours 12 → 1/2 with pm=1.
  - hours 13 → 0/1 with pm=1.
  - Toggling mode_12h mid-run leaves hours unchanged.
